// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding imem request, 2-entry output buffer,
// redirect flush with drop of an in-flight response.
//
// state    | meaning
// ST_FETCH | may issue a request when the buffer has room and no redirect
// ST_WAIT  | one request outstanding, waiting for imem_rsp_valid
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ST_FETCH, ST_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [1:0]  r_count;
  logic [31:0] r_head_instr;
  logic [31:0] r_head_pc;
  logic [31:0] r_tail_instr;
  logic [31:0] r_tail_pc;

  logic w_full;
  logic w_req_fire;
  logic w_rsp;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == 2'(BUF_DEPTH));
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_rsp      = (r_state == ST_WAIT) && imem_rsp_valid;
  assign w_push     = w_rsp && !r_drop && !redirect_valid;
  assign w_pop      = out_valid && out_ready && !redirect_valid;

  assign imem_addr  = r_pc;
  assign out_valid  = (r_count != 2'd0);
  assign out_instr  = r_head_instr;
  assign out_pc     = r_head_pc;
  assign out_opcode = r_head_instr[6:0];
  assign out_funct3 = r_head_instr[14:12];
  assign out_funct7 = r_head_instr[30];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: if (w_req_fire)     w_state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_rsp_valid) w_state_nxt = ST_FETCH;
      default:                      w_state_nxt = ST_FETCH;
    endcase
  end

  // Gated by rst so the request stays low even before the first reset edge.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && (r_state == ST_FETCH) && !w_full && !redirect_valid)
      imem_req_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_count      <= 2'd0;
      r_head_instr <= NOP;
      r_head_pc    <= 32'd0;
      r_tail_instr <= NOP;
      r_tail_pc    <= 32'd0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc & 32'hFFFF_FFFC;
      r_count <= 2'd0;
      // A response landing with the redirect retires the request, so nothing is left to drop.
      if (r_state == ST_WAIT) r_drop <= !imem_rsp_valid;
    end else begin
      if (w_push) r_pc <= r_pc + 32'd4;
      if (w_rsp)  r_drop <= 1'b0;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_instr <= imem_rsp_data;
            r_head_pc    <= r_pc;
          end else begin
            r_tail_instr <= imem_rsp_data;
            r_tail_pc    <= r_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_instr <= r_tail_instr;
          r_head_pc    <= r_tail_pc;
          r_count      <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_instr <= imem_rsp_data;
            r_head_pc    <= r_pc;
          end else begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_instr <= imem_rsp_data;
            r_tail_pc    <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
